// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH/EXEC sequencing with handshaked instruction ROM and data memory,
// parametrised widths, and halt detection on a jump-to-self with no destination.
module hack_cpu_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int PC_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic              instr_valid,
  output logic              instr_req,
  output logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] inM,
  input  logic              inM_valid,
  output logic              readM,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] addressM,
  output logic              retire,
  output logic              halted
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_q, d_q, ir_q;
  logic [DATA_W-1:0] a_nxt, d_nxt, ir_nxt;
  logic [PC_W-1:0]   pc_nxt, pc_inc;

  logic is_c, sel_m, zx, nx, zy, ny, fn, no;
  logic dst_a, dst_d, dst_m, j_lt, j_eq, j_gt;

  assign is_c  = ir_q[DATA_W-1];
  assign sel_m = ir_q[12];
  assign zx    = ir_q[11];
  assign nx    = ir_q[10];
  assign zy    = ir_q[9];
  assign ny    = ir_q[8];
  assign fn    = ir_q[7];
  assign no    = ir_q[6];
  assign dst_a = ir_q[5];
  assign dst_d = ir_q[4];
  assign dst_m = ir_q[3];
  assign j_lt  = ir_q[2];
  assign j_eq  = ir_q[1];
  assign j_gt  = ir_q[0];

  logic [DATA_W-1:0] x0, x1, y0, y1, f_out, alu_out;
  logic zr, ng, jump, rd_ok, done, self_loop;

  always_comb begin
    x0      = zx ? '0 : d_q;
    x1      = nx ? ~x0 : x0;
    y0      = zy ? '0 : (sel_m ? inM : a_q);
    y1      = ny ? ~y0 : y0;
    f_out   = fn ? (x1 + y1) : (x1 & y1);
    alu_out = no ? ~f_out : f_out;
  end

  assign zr        = (alu_out == '0);
  assign ng        = alu_out[DATA_W-1];
  assign jump      = (j_lt & ng) | (j_eq & zr) | (j_gt & ~zr & ~ng);
  assign rd_ok     = ~sel_m | inM_valid;
  assign done      = rd_ok & (~dst_m | mem_ready);
  // Jump target equals this instruction's own address and nothing is written: a halt idiom.
  assign self_loop = jump & (a_q[PC_W-1:0] == pc) & ~dst_a & ~dst_d & ~dst_m;
  assign pc_inc    = pc + PC_W'(1);

  assign outM     = alu_out;
  assign addressM = a_q[ADDR_W-1:0];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    a_nxt     = a_q;
    d_nxt     = d_q;
    ir_nxt    = ir_q;
    instr_req = 1'b0;
    readM     = 1'b0;
    writeM    = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    unique case (state)
      FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_nxt    = instruction;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!is_c) begin
          a_nxt     = ir_q;
          pc_nxt    = pc_inc;
          retire    = 1'b1;
          state_nxt = FETCH;
        end else begin
          readM  = sel_m;
          writeM = dst_m & rd_ok;
          if (done) begin
            if (dst_a) a_nxt = alu_out;
            if (dst_d) d_nxt = alu_out;
            pc_nxt    = jump ? a_q[PC_W-1:0] : pc_inc;
            retire    = 1'b1;
            state_nxt = self_loop ? HALT : FETCH;
          end
        end
      end
      HALT:    halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
    if (reset) begin
      readM  = 1'b0;
      writeM = 1'b0;
      retire = 1'b0;
      halted = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= '0;
      a_q   <= '0;
      d_q   <= '0;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      a_q   <= a_nxt;
      d_q   <= d_nxt;
      ir_q  <= ir_nxt;
    end
  end
endmodule
